// File: rtl/lw_sha_bus_host_sequencer.sv
// Host-side bus sequencer for the lightweight SHA/HMAC register slave.
// Programs CFG/CTL, streams DIN words, polls STS and drains the digest.
module lw_sha_bus_host_sequencer #(
  parameter int BUS_W      = 32,
  parameter int HASH_BEATS = 8,
  parameter int POLL_LIMIT = 1024,
  parameter int CNT_W      = 11
) (
  input  logic             clk_i,
  input  logic             resetn_i,
  input  logic             start_i,
  input  logic [3:0]       opcode_i,
  input  logic             newkey_i,
  input  logic             abort_i,
  input  logic [BUS_W-1:0] msg_data_i,
  input  logic             msg_valid_i,
  input  logic             msg_last_i,
  output logic             msg_ready_o,
  output logic             wr_o,
  input  logic             wr_ack_i,
  output logic [11:0]      waddr_o,
  output logic [BUS_W-1:0] wdata_o,
  input  logic             slv_error_i,
  output logic             rd_o,
  output logic [11:0]      raddr_o,
  input  logic [BUS_W-1:0] rdata_i,
  input  logic             read_valid_i,
  output logic             rd_ack_o,
  output logic [BUS_W-1:0] digest_o,
  output logic             digest_valid_o,
  output logic             digest_last_o,
  input  logic             digest_ready_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [1:0]       err_o
);

  localparam int BW = (HASH_BEATS > 1) ? $clog2(HASH_BEATS) : 1;

  localparam logic [11:0] A_CFG  = 12'h010;
  localparam logic [11:0] A_CTL  = 12'h020;
  localparam logic [11:0] A_STS  = 12'h030;
  localparam logic [11:0] A_HASH = 12'h100;
  localparam logic [11:0] A_DIN  = 12'h140;

  typedef enum logic [3:0] {
    IDLE, WR_CFG, WR_INIT, POLL_RDY, WR_DIN, WR_LAST,
    POLL_AVL, RD_HASH, PUSH, WR_ABORT, CLR_STS, FINISH
  } state_e;

  state_e           state_q;
  logic             wr_q, rd_q;
  logic [11:0]      waddr_q, raddr_q;
  logic [BUS_W-1:0] wdata_q, digest_q;
  logic             dvalid_q, dlast_q, done_q;
  logic [1:0]       err_q;
  logic [3:0]       opcode_q;
  logic             newkey_q, last_q, abort_q;
  logic [CNT_W-1:0] poll_q;
  logic [BW-1:0]    beat_q;

  logic abrt, can_abort, poll_to, beat_end;

  assign abrt      = abort_i | abort_q;
  assign can_abort = !(state_q == IDLE || state_q == WR_ABORT ||
                       state_q == FINISH);
  assign poll_to   = (poll_q == CNT_W'(POLL_LIMIT - 1));
  assign beat_end  = (beat_q == BW'(HASH_BEATS - 1));

  assign wr_o           = wr_q;
  assign waddr_o        = waddr_q;
  assign wdata_o        = wdata_q;
  assign rd_o           = rd_q;
  assign raddr_o        = raddr_q;
  assign rd_ack_o       = rd_q & read_valid_i;
  assign msg_ready_o    = (state_q == WR_DIN) & wr_q & wr_ack_i &
                          ~slv_error_i;
  assign digest_o       = digest_q;
  assign digest_valid_o = dvalid_q;
  assign digest_last_o  = dlast_q;
  assign busy_o         = (state_q != IDLE);
  assign done_o         = done_q;
  assign err_o          = err_q;

  // Sequencer FSM: one bus transfer per state, registered strobes.
  always_ff @(posedge clk_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q  <= IDLE;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      waddr_q  <= '0;
      raddr_q  <= '0;
      wdata_q  <= '0;
      digest_q <= '0;
      dvalid_q <= 1'b0;
      dlast_q  <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 2'd0;
      opcode_q <= '0;
      newkey_q <= 1'b0;
      last_q   <= 1'b0;
      abort_q  <= 1'b0;
      poll_q   <= '0;
      beat_q   <= '0;
    end else begin
      done_q <= 1'b0;
      if (abort_i && can_abort) abort_q <= 1'b1;
      if (abrt && can_abort && !wr_q && !rd_q) begin
        state_q  <= WR_ABORT;
        dvalid_q <= 1'b0;
        dlast_q  <= 1'b0;
        if (err_q == 2'd0) err_q <= 2'd2;
      end else begin
        unique case (state_q)
          IDLE: if (start_i) begin
            opcode_q <= opcode_i;
            newkey_q <= newkey_i;
            err_q    <= 2'd0;
            poll_q   <= '0;
            beat_q   <= '0;
            abort_q  <= 1'b0;
            state_q  <= WR_CFG;
          end
          WR_CFG: if (!wr_q) begin
            wr_q    <= 1'b1;
            waddr_q <= A_CFG;
            wdata_q <= BUS_W'({newkey_q, opcode_q});
          end else if (wr_ack_i) begin
            wr_q    <= 1'b0;
            poll_q  <= '0;
            state_q <= WR_INIT;
          end
          WR_INIT: if (!wr_q) begin
            wr_q    <= 1'b1;
            waddr_q <= A_CTL;
            wdata_q <= BUS_W'(1);
          end else if (wr_ack_i) begin
            wr_q    <= 1'b0;
            poll_q  <= '0;
            state_q <= POLL_RDY;
          end
          POLL_RDY: if (!rd_q) begin
            rd_q    <= 1'b1;
            raddr_q <= A_STS;
          end else if (read_valid_i) begin
            rd_q <= 1'b0;
            if (rdata_i[5]) begin
              err_q   <= 2'd3;
              state_q <= WR_ABORT;
            end else if (rdata_i[1] && msg_valid_i) begin
              state_q <= WR_DIN;
            end else if (poll_to) begin
              err_q   <= 2'd1;
              state_q <= WR_ABORT;
            end else begin
              poll_q <= poll_q + 1'b1;
            end
          end
          WR_DIN: if (!wr_q) begin
            wr_q    <= 1'b1;
            waddr_q <= A_DIN;
            wdata_q <= msg_data_i;
            last_q  <= msg_last_i;
          end else if (wr_ack_i) begin
            wr_q <= 1'b0;
            if (slv_error_i) begin
              state_q <= CLR_STS;
            end else begin
              poll_q  <= '0;
              state_q <= last_q ? WR_LAST : POLL_RDY;
            end
          end
          CLR_STS: if (!wr_q) begin
            wr_q    <= 1'b1;
            waddr_q <= A_STS;
            wdata_q <= BUS_W'(8);
          end else if (wr_ack_i) begin
            wr_q    <= 1'b0;
            poll_q  <= '0;
            state_q <= POLL_RDY;
          end
          WR_LAST: if (!wr_q) begin
            wr_q    <= 1'b1;
            waddr_q <= A_CTL;
            wdata_q <= BUS_W'(2);
          end else if (wr_ack_i) begin
            wr_q    <= 1'b0;
            poll_q  <= '0;
            state_q <= POLL_AVL;
          end
          POLL_AVL: if (!rd_q) begin
            rd_q    <= 1'b1;
            raddr_q <= A_STS;
          end else if (read_valid_i) begin
            rd_q <= 1'b0;
            if (rdata_i[5]) begin
              err_q   <= 2'd3;
              state_q <= WR_ABORT;
            end else if (rdata_i[0]) begin
              beat_q  <= '0;
              state_q <= RD_HASH;
            end else if (poll_to) begin
              err_q   <= 2'd1;
              state_q <= WR_ABORT;
            end else begin
              poll_q <= poll_q + 1'b1;
            end
          end
          RD_HASH: if (!rd_q) begin
            rd_q    <= 1'b1;
            raddr_q <= A_HASH + 12'(beat_q) * 12'(BUS_W / 8);
          end else if (read_valid_i) begin
            rd_q <= 1'b0;
            if (abrt) begin
              if (err_q == 2'd0) err_q <= 2'd2;
              state_q <= WR_ABORT;
            end else begin
              digest_q <= rdata_i;
              dvalid_q <= 1'b1;
              dlast_q  <= beat_end;
              state_q  <= PUSH;
            end
          end
          PUSH: if (digest_ready_i) begin
            dvalid_q <= 1'b0;
            dlast_q  <= 1'b0;
            if (dlast_q) begin
              state_q <= FINISH;
            end else begin
              beat_q  <= beat_q + 1'b1;
              state_q <= RD_HASH;
            end
          end
          WR_ABORT: if (!wr_q) begin
            wr_q    <= 1'b1;
            waddr_q <= A_CTL;
            wdata_q <= BUS_W'(4);
          end else if (wr_ack_i) begin
            wr_q    <= 1'b0;
            state_q <= FINISH;
          end
          FINISH: begin
            done_q  <= 1'b1;
            abort_q <= 1'b0;
            state_q <= IDLE;
          end
          default: state_q <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_lw_sha_bus_host_sequencer.sv
// Bench for lw_sha_bus_host_sequencer: randomized slave/source/sink
// against a transaction-list model of the expected bus traffic.
module tb_lw_sha_bus_host_sequencer;

  localparam int BUS_W = 32;
  localparam int HB    = 8;
  localparam int PL    = 16;
  localparam int CW    = 5;

  logic             clk_i = 1'b0;
  logic             resetn_i = 1'b1;
  logic             start_i, newkey_i, abort_i;
  logic [3:0]       opcode_i;
  logic [BUS_W-1:0] msg_data_i;
  logic             msg_valid_i, msg_last_i, msg_ready_o;
  logic             wr_o, wr_ack_i, slv_error_i;
  logic [11:0]      waddr_o, raddr_o;
  logic [BUS_W-1:0] wdata_o, rdata_i, digest_o;
  logic             rd_o, read_valid_i, rd_ack_o;
  logic             digest_valid_o, digest_last_o, digest_ready_i;
  logic             busy_o, done_o;
  logic [1:0]       err_o;

  always #5 clk_i = ~clk_i;

  lw_sha_bus_host_sequencer #(
    .BUS_W(BUS_W), .HASH_BEATS(HB), .POLL_LIMIT(PL), .CNT_W(CW)
  ) dut (
    .clk_i(clk_i), .resetn_i(resetn_i), .start_i(start_i),
    .opcode_i(opcode_i), .newkey_i(newkey_i), .abort_i(abort_i),
    .msg_data_i(msg_data_i), .msg_valid_i(msg_valid_i),
    .msg_last_i(msg_last_i), .msg_ready_o(msg_ready_o),
    .wr_o(wr_o), .wr_ack_i(wr_ack_i), .waddr_o(waddr_o),
    .wdata_o(wdata_o), .slv_error_i(slv_error_i), .rd_o(rd_o),
    .raddr_o(raddr_o), .rdata_i(rdata_i), .read_valid_i(read_valid_i),
    .rd_ack_o(rd_ack_o), .digest_o(digest_o),
    .digest_valid_o(digest_valid_o), .digest_last_o(digest_last_o),
    .digest_ready_i(digest_ready_i), .busy_o(busy_o), .done_o(done_o),
    .err_o(err_o)
  );

  int npass = 0;
  int ntot  = 0;

  int          n_words, stall_k, rej_idx, avl_dly, abort_beat;
  bit          avl_never, hold_din;
  logic [31:0] words[$];
  logic [31:0] hseed;
  logic [3:0]  op;
  logic        nk;

  logic [44:0] log_q[$];
  logic [44:0] exp_q[$];
  logic [31:0] dig_q[$];
  logic        dlast_q[$];
  int          n_done, n_ready;
  bit          both_hi;

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    ntot++;
    assert (obs === expv) npass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
  endtask

  function automatic logic [31:0] hw(input logic [11:0] a);
    return hseed ^ (32'(a) * 32'h9E3779B9);
  endfunction

  function automatic logic [44:0] tx(input bit w, input logic [11:0] a,
                                     input logic [31:0] d);
    return {w, a, d};
  endfunction

  task automatic idle_inputs();
    start_i = 0; abort_i = 0; wr_ack_i = 0; slv_error_i = 0;
    read_valid_i = 0; rdata_i = '0; msg_valid_i = 0; msg_last_i = 0;
    msg_data_i = '0; digest_ready_i = 0;
  endtask

  task automatic rand_words(input int n);
    words.delete();
    for (int i = 0; i < n; i++) words.push_back($urandom);
    n_words = n;
  endtask

  task automatic run();
    int src, din_cnt, stall_left, avl_left, wlat, rlat;
    bit avl_ph, wx, rx, abort_sent, chk_drop, fin;
    log_q.delete(); dig_q.delete(); dlast_q.delete();
    n_done = 0; n_ready = 0; both_hi = 0;
    src = 0; din_cnt = 0; stall_left = stall_k; avl_left = avl_dly;
    wlat = 0; rlat = 0;
    avl_ph = 0; wx = 0; rx = 0; abort_sent = 0; chk_drop = 0; fin = 0;
    @(negedge clk_i);
    start_i = 1; opcode_i = op; newkey_i = nk;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      @(negedge clk_i);
      start_i = 0; abort_i = 0; wr_ack_i = 0; slv_error_i = 0;
      read_valid_i = 0; rdata_i = '0;
      if (wr_o && rd_o) both_hi = 1;
      if (chk_drop) begin
        chk("abort_drop_valid", digest_valid_o, 0);
        chk_drop = 0;
      end
      if (done_o) begin
        n_done++;
        fin = 1;
        chk("idle_at_done", busy_o, 0);
      end
      if (hold_din && wr_o && waddr_o == 12'h140) begin
        #2 resetn_i = 0;
        #1 chk("rst_async_wr", wr_o, 0);
        chk("rst_async_busy", busy_o, 0);
        fin = 1;
      end else begin
        if (wr_o) begin
          if (!wx) begin wx = 1; wlat = $urandom_range(0, 2); end
          if (wlat == 0) begin
            wr_ack_i = 1; wx = 0;
            log_q.push_back(tx(1, waddr_o, wdata_o));
            if (waddr_o == 12'h020 && wdata_o == 1) stall_left = stall_k;
            if (waddr_o == 12'h020 && wdata_o == 2) avl_ph = 1;
            if (waddr_o == 12'h140) begin
              din_cnt++;
              if (din_cnt == rej_idx) slv_error_i = 1;
              else stall_left = stall_k;
            end
          end else wlat--;
        end
        if (rd_o) begin
          if (!rx) begin rx = 1; rlat = $urandom_range(0, 2); end
          if (rlat == 0) begin
            read_valid_i = 1; rx = 0;
            log_q.push_back(tx(0, raddr_o, 32'h0));
            if (raddr_o == 12'h030) begin
              if (!avl_ph) begin
                if (stall_left > 0) stall_left--;
                else rdata_i = 32'h2;
              end else if (!avl_never) begin
                if (avl_left > 0) avl_left--;
                else rdata_i = 32'h1;
              end
            end else rdata_i = hw(raddr_o);
          end else rlat--;
        end
        msg_valid_i = (src < n_words);
        msg_data_i  = (src < n_words) ? words[src] : '0;
        msg_last_i  = (src == n_words - 1);
        if (abort_beat >= 0 && dig_q.size() == abort_beat &&
            digest_valid_o) begin
          digest_ready_i = 0;
          if (!abort_sent) begin
            abort_i = 1; abort_sent = 1; chk_drop = 1;
          end
        end else digest_ready_i = 1'($urandom_range(0, 1));
        #1;
        if (rd_o) chk("rd_ack", rd_ack_o, read_valid_i);
        if (msg_ready_o) begin n_ready++; src++; end
        if (digest_valid_o && digest_ready_i) begin
          dig_q.push_back(digest_o);
          dlast_q.push_back(digest_last_o);
        end
      end
    end
    chk("run_finished", fin, 1);
  endtask

  task automatic verify(input int exp_err);
    int dw, nr, nb;
    exp_q.delete();
    exp_q.push_back(tx(1, 12'h010, 32'({nk, op})));
    exp_q.push_back(tx(1, 12'h020, 32'h1));
    dw = 0;
    for (int i = 0; i < n_words; i++) begin
      repeat (stall_k) exp_q.push_back(tx(0, 12'h030, 0));
      exp_q.push_back(tx(0, 12'h030, 0));
      exp_q.push_back(tx(1, 12'h140, words[i]));
      dw++;
      if (dw == rej_idx) begin
        exp_q.push_back(tx(1, 12'h030, 32'h8));
        exp_q.push_back(tx(0, 12'h030, 0));
        exp_q.push_back(tx(1, 12'h140, words[i]));
        dw++;
      end
    end
    exp_q.push_back(tx(1, 12'h020, 32'h2));
    if (avl_never) begin
      repeat (PL) exp_q.push_back(tx(0, 12'h030, 0));
      exp_q.push_back(tx(1, 12'h020, 32'h4));
      nb = 0;
    end else begin
      repeat (avl_dly + 1) exp_q.push_back(tx(0, 12'h030, 0));
      nr = (abort_beat >= 0) ? abort_beat + 1 : HB;
      nb = (abort_beat >= 0) ? abort_beat : HB;
      for (int b = 0; b < nr; b++)
        exp_q.push_back(tx(0, 12'h100 + 12'(4 * b), 0));
      if (abort_beat >= 0) exp_q.push_back(tx(1, 12'h020, 32'h4));
    end
    chk("bus_txn_count", log_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++)
      chk($sformatf("bus_txn%0d", i), log_q[i], exp_q[i]);
    chk("digest_beats", dig_q.size(), nb);
    for (int b = 0; b < nb && b < dig_q.size(); b++) begin
      chk($sformatf("digest%0d", b), dig_q[b], hw(12'h100 + 12'(4 * b)));
      chk($sformatf("dlast%0d", b), dlast_q[b], (b == HB - 1));
    end
    chk("done_pulses", n_done, 1);
    chk("err_code", err_o, exp_err);
    chk("msg_ready_cnt", n_ready, n_words);
    chk("one_strobe", both_hi, 0);
    @(negedge clk_i);
    chk("done_one_cycle", done_o, 0);
    idle_inputs();
  endtask

  task automatic defaults();
    stall_k = 0; rej_idx = 0; avl_dly = $urandom_range(0, 3);
    abort_beat = -1; avl_never = 0; hold_din = 0;
    hseed = $urandom; op = 4'($urandom); nk = 1'($urandom);
  endtask

  initial begin
    idle_inputs();
    opcode_i = 0; newkey_i = 0;
    #1 resetn_i = 0;
    #10;
    chk("rst_wr", wr_o, 0);
    chk("rst_rd", rd_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_err", err_o, 0);
    chk("rst_dvalid", digest_valid_o, 0);
    @(negedge clk_i) resetn_i = 1;

    defaults();
    op = 4'h0; nk = 0;
    words = '{32'h61626380, 32'h0, 32'h18};
    n_words = 3;
    run(); verify(0);

    defaults();
    stall_k = 5; rand_words(3);
    run(); verify(0);

    defaults();
    rej_idx = 2; stall_k = $urandom_range(0, 2); rand_words(3);
    run(); verify(0);

    defaults();
    avl_never = 1; rand_words(2);
    run(); verify(1);

    defaults();
    abort_beat = 3; rand_words(2);
    run(); verify(2);
    chk("abort_idle", busy_o, 0);

    defaults();
    hold_din = 1; rand_words(2);
    run();
    idle_inputs();
    @(negedge clk_i);
    chk("rst2_wr", wr_o, 0);
    chk("rst2_err", err_o, 0);
    resetn_i = 1;
    defaults();
    rand_words(2);
    run(); verify(0);
    chk("restart_cfg_first", log_q[0][44:32], {1'b1, 12'h010});

    for (int k = 0; k < 4; k++) begin
      defaults();
      rand_words($urandom_range(1, 6));
      stall_k = $urandom_range(0, 3);
      rej_idx = $urandom_range(0, n_words);
      run(); verify(0);
    end

    $display("%0d/%0d checks passed", npass, ntot);
    $finish;
  end

endmodule
